icache_responder: RTL and testbench

//  Cache-side responder for the datapath's instruction-fetch port: a direct-mapped,
//  one-word-block, read-only instruction cache. Serves hits combinationally and

---
 rtl/icache_responder.sv | 85 ++++++++
 tb/tb_icache_responder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-block, read-only instruction cache.
// Hits are answered in the same cycle; misses are refilled from memory by a two-state FSM.
module icache_responder #(
    parameter int SETS   = 16,
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic [ADDR_W-1:0] imemaddr,
    output logic              ihit,
    output logic [ADDR_W-1:0] imemload,
    output logic              iREN,
    output logic [ADDR_W-1:0] iaddr,
    input  logic              iwait,
    input  logic [ADDR_W-1:0] iload
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

    state_t            state_q;
    logic [ADDR_W-3:0] miss_q;
    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [ADDR_W-1:0] data_q [SETS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  miss_idx;
    logic [TAG_W-1:0]  miss_tag;
    logic              hit;
    logic              fill;
    logic              unused_byte_off;

    assign idx             = imemaddr[IDX_W+1:2];
    assign tag             = imemaddr[ADDR_W-1:IDX_W+2];
    assign miss_idx        = miss_q[IDX_W-1:0];
    assign miss_tag        = miss_q[ADDR_W-3:IDX_W];
    assign unused_byte_off = ^imemaddr[1:0];

    assign hit  = imemREN & valid_q[idx] & (tag_q[idx] == tag);
    assign fill = (state_q == FETCH) & ~iwait;

    // Nothing is forwarded from iload; the filled word is served from the frame next cycle.
    assign ihit     = (state_q == IDLE) & hit;
    assign imemload = ihit ? data_q[idx] : '0;
    assign iREN     = (state_q == FETCH);
    assign iaddr    = iREN ? {miss_q, 2'b00} : '0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            miss_q  <= '0;
            valid_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (imemREN && !hit) begin
                        miss_q  <= imemaddr[ADDR_W-1:2];
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    // The latched miss address owns the fill; request changes wait until IDLE.
                    if (!iwait) begin
                        valid_q[miss_idx] <= 1'b1;
                        state_q           <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag and data carry no reset; the valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// Scoreboard bench for icache_responder: a cache model keyed by word address predicts
// each cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_icache_responder;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = '0;
    logic        iwait = 1'b1;
    logic [31:0] iload = '0;
    logic        ihit;
    logic        iREN;
    logic [31:0] imemload;
    logic [31:0] iaddr;

    always #5 CLK = ~CLK;

    icache_responder #(.SETS(16), .ADDR_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload)
    );

    typedef struct {
        logic        ihit;
        logic [31:0] load;
        logic        iren;
        logic [31:0] iaddr;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: which word address each set holds, plus an outstanding miss.
    bit          mv    [16];
    logic [29:0] mword [16];
    logic [31:0] mdata [16];
    bit          pend = 1'b0;
    logic [31:0] paddr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("ihit",     {31'b0, ihit}, {31'b0, e.ihit});
            check("imemload", imemload,      e.load);
            check("iREN",     {31'b0, iREN}, {31'b0, e.iren});
            check("iaddr",    iaddr,         e.iaddr);
        end
    end

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // Drive one cycle's inputs (called at posedge+1), predict the outputs, advance the model.
    task automatic cycle(input bit rn, input bit ren, input logic [31:0] a,
                         input bit iw, input logic [31:0] ld);
        exp_t e;
        bit   hit;
        int   i;
        int   j;
        nRST     = rn;
        imemREN  = ren;
        imemaddr = a;
        iwait    = iw;
        iload    = ld;
        i = int'(a[5:2]);
        e.ihit = 1'b0; e.load = '0; e.iren = 1'b0; e.iaddr = '0;
        if (!rn) begin
            for (int k = 0; k < 16; k++) mv[k] = 1'b0;
            pend = 1'b0;
        end else if (!pend) begin
            hit = ren && mv[i] && (mword[i] == a[31:2]);
            e.ihit = hit;
            e.load = hit ? mdata[i] : 32'h0;
            if (ren && !hit) begin
                pend  = 1'b1;
                paddr = a;
            end
        end else begin
            e.iren  = 1'b1;
            e.iaddr = {paddr[31:2], 2'b00};
            if (!iw) begin
                j = int'(paddr[5:2]);
                mv[j]    = 1'b1;
                mword[j] = paddr[31:2];
                mdata[j] = ld;
                pend     = 1'b0;
            end
        end
        sbq.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    // Memory responds with random wait states and an address-derived word.
    task automatic rcycle(input bit ren, input logic [31:0] a);
        bit iw;
        logic [31:0] ld;
        if (pend) begin
            iw = ($urandom_range(0, 2) != 0);
            ld = iw ? $urandom : memfn({paddr[31:2], 2'b00});
        end else begin
            iw = $urandom_range(0, 1) != 0;
            ld = $urandom;
        end
        cycle(1'b1, ren, a, iw, ld);
    endtask

    initial begin
        logic [31:0] a;
        for (int k = 0; k < 16; k++) begin
            mv[k] = 1'b0; mword[k] = '0; mdata[k] = '0;
        end
        @(posedge CLK);
        #1;
        // Reset state
        cycle(1'b0, 1'b1, 32'h4, 1'b0, 32'h1234_5678);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);

        // Cold miss with three wait states, then same-cycle hit
        cycle(1'b1, 1'b1, 32'h4, 1'b1, 32'h0);
        cycle(1'b1, 1'b1, 32'h4, 1'b1, 32'hFFFF_FFFF);
        cycle(1'b1, 1'b1, 32'h4, 1'b1, 32'h0);
        cycle(1'b1, 1'b1, 32'h4, 1'b1, 32'h0);
        cycle(1'b1, 1'b1, 32'h4, 1'b0, 32'h2001_0005);
        cycle(1'b1, 1'b1, 32'h4, 1'b1, 32'h0);
        cycle(1'b1, 1'b1, 32'h4, 1'b0, 32'h5555_5555);
        // Byte offset and imemREN low
        cycle(1'b1, 1'b1, 32'h7, 1'b1, 32'h0);
        cycle(1'b1, 1'b0, 32'h4, 1'b0, 32'h0);

        // Conflict on index 1
        cycle(1'b1, 1'b1, 32'h44, 1'b1, 32'h0);
        cycle(1'b1, 1'b1, 32'h44, 1'b0, 32'hDEAD_BEEF);
        cycle(1'b1, 1'b1, 32'h44, 1'b1, 32'h0);
        cycle(1'b1, 1'b1, 32'h4,  1'b1, 32'h0);
        cycle(1'b1, 1'b1, 32'h4,  1'b0, 32'h2001_0005);
        cycle(1'b1, 1'b1, 32'h4,  1'b1, 32'h0);

        // Retarget during fetch, and imemREN dropping mid-fetch
        cycle(1'b1, 1'b1, 32'h100, 1'b1, 32'h0);
        cycle(1'b1, 1'b1, 32'h200, 1'b1, 32'h0);
        cycle(1'b1, 1'b0, 32'h200, 1'b1, 32'h0);
        cycle(1'b1, 1'b1, 32'h200, 1'b0, 32'hCAFE_0100);
        cycle(1'b1, 1'b1, 32'h100, 1'b1, 32'h0);
        cycle(1'b1, 1'b1, 32'h200, 1'b1, 32'h0);
        cycle(1'b1, 1'b1, 32'h200, 1'b0, 32'hCAFE_0200);
        cycle(1'b1, 1'b1, 32'h200, 1'b1, 32'h0);

        // Reset asserted mid-fetch between clock edges
        cycle(1'b1, 1'b1, 32'h300, 1'b1, 32'h0);
        cycle(1'b1, 1'b1, 32'h300, 1'b1, 32'h0);
        cycle(1'b0, 1'b1, 32'h300, 1'b1, 32'h0);
        cycle(1'b0, 1'b1, 32'h300, 1'b0, 32'h0BAD_0300);
        cycle(1'b1, 1'b1, 32'h4,   1'b1, 32'h0);
        cycle(1'b1, 1'b1, 32'h4,   1'b0, 32'h2001_0005);
        cycle(1'b1, 1'b1, 32'h4,   1'b1, 32'h0);

        // Randomized traffic over a small address pool to force hits and conflicts
        for (int n = 0; n < 3000; n++) begin
            a = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 299) == 0) begin
                cycle(1'b0, 1'b1, a, 1'b1, $urandom);
            end else begin
                rcycle($urandom_range(0, 3) != 0, a);
            end
        end
        for (int n = 0; n < 8; n++) rcycle(1'b0, 32'h0);

        @(negedge CLK);
        check("sb_drain", 32'(sbq.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
